mems_dac_spi: RTL and testbench
===============================

# mems_dac_spi

Serial transmitter between the MEMS mirror controller and the quad 16-bit DAC that drives the mirror axes. On each one-cycle `start` pulse it captures one 24-bit DAC command word from the synchronous pattern ROM (output valid one cycle after the address), then shifts it MSB-first over a 3-wire SPI link (`sync_n`, `sclk`, `mosi`). It reports `busy` back to the controller and pulses `done` when the frame is complete.

## Interface
- `CLK_DIV`, default 2: `sclk` half-period in `clk` cycles; must be ≥1.
- `WORD_BITS`, default 24: bits per SPI frame.
- `GAP`, default 2: minimum `clk` cycles `sync_n` stays high between frames; must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle transfer request from the controller.
- `data_in`  in  WORD_BITS  ROM output word; sampled one cycle after `start`.
- `busy`  out  1  transfer in progress; registered.
- `done`  out  1  one-cycle completion pulse.
- `sync_n`  out  1  DAC frame select, active low.
- `sclk`  out  1  serial clock; idles high.
- `mosi`  out  1  serial data.
- `ldac_n`  out  1  DAC load strobe, active low.

## Operation
- States: IDLE, LOAD, SHIFT, HOLD, GAP, LDAC (LDAC exists only when the macro is set).
- IDLE: when `start`=1, go to LOAD and set `busy`=1 from the next cycle. While `busy`=1, `start` is ignored and not queued.
- LOAD, 1 cycle: latch `data_in` into the shift register. Load `bit_cnt`=WORD_BITS.
- SHIFT: drive `sync_n`=0 and `mosi`=sreg MSB.
  - `sclk` stays high for CLK_DIV cycles, then low for CLK_DIV cycles. The DAC samples on the falling edge.
  - On each rising edge: shift left and decrement `bit_cnt`.
  - After the WORD_BITS-th low phase, `sclk` returns high and the state goes to HOLD.
- HOLD: keep `sync_n`=0 and `sclk`=1 for CLK_DIV cycles, then go to GAP.
- GAP: `sync_n`=1 and `mosi`=0 for GAP cycles. Then go to LDAC if the macro is set, otherwise IDLE.
- On the transition into IDLE: `busy`=0 and `done`=1 for exactly that one cycle.
- Width rules:
  - Divider counter: $clog2(CLK_DIV+1) bits.
  - `bit_cnt`: $clog2(WORD_BITS+1) bits.
  - The state machine never wraps mid-frame.
- Reset at any cycle:
  - Next cycle: `sync_n`=1, `sclk`=1, `mosi`=0, `busy`=0, `done`=0, `ldac_n`=1, state IDLE.
  - A partial frame is abandoned and no `done` is issued.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `sync_n`=1, `sclk`=1, `mosi`=0, `ldac_n`=1.
- With `start` at cycle N: `busy` rises at N+1 and `sync_n` falls at N+2.
- Busy length T = 1 + 2·CLK_DIV·WORD_BITS + CLK_DIV + GAP (+CLK_DIV with the macro).
  - `busy`=1 for cycles N+1..N+T.
  - `done`=1 and `busy`=0 at N+T+1.
- Defaults give T=101 without the macro and 103 with it.
- `mosi` changes only while `sclk`=1. It is stable for CLK_DIV cycles on each side of every falling edge.
- Controller compatibility: the controller re-arms on `!busy && !start_q`. The earliest next `start` is N+T+1, which yields ≥GAP cycles of `sync_n` high between frames.

## Configuration
- `MEMS_SPI_LDAC_EN` defined:
  - After GAP, drive `ldac_n`=0 for CLK_DIV cycles, then return to IDLE.
  - All four DAC channels update simultaneously.
- Undefined:
  - The LDAC state is not built and `ldac_n` is tied to 1.
  - The DAC updates per-channel on `sync_n` rising.

## Structure
- Shared package `mems_spi_pkg` holds:
  - the state enum;
  - default WORD_BITS;
  - DAC command-field positions and constants: cmd [21:19], addr [18:16], data [15:0], CMD_WRITE_UPDATE, CMD_RESET, CMD_REF_SETUP. These are shared with the ROM generator.
- One sub-module: `mems_spi_clkgen`, the CLK_DIV divider.
  - Outputs one-cycle `rise_tick`/`fall_tick`.
  - Enabled only in SHIFT/HOLD.

## Test plan
- Reset: hold `rst` 3 cycles -> `sync_n`=1, `sclk`=1, `mosi`=0, `busy`=0, `done`=0, `ldac_n`=1.
- Single frame: `data_in`=24'hA5F00F, defaults, `start` at N -> 24 falling edges; bits sampled at falling edges reassemble 0xA5F00F; `busy` high N+1..N+101; `done` at N+102.
- Start while busy: pulse `start` at N+20 with `data_in`=24'h123456 -> ignored; only 0xA5F00F is transmitted and exactly one `done`.
- Back-to-back with controller model: words 0x280000, 0x380001, 0x1F8000 -> three frames, `sync_n` high ≥2 cycles between them, MSB-first order correct.
- Reset mid-frame: assert `rst` after the 10th falling edge -> next cycle `sync_n`=1, `busy`=0, no `done`; the following frame transmits correctly.
- `MEMS_SPI_LDAC_EN` with CLK_DIV=3 -> `ldac_n` low exactly 3 cycles, starting 2 cycles after `sync_n` rises; `busy` length 1+144+3+2+3=153.

Source files
------------

// File: rtl/mems_spi_pkg.sv
// Shared definitions for the MEMS mirror DAC SPI link; the DAC field layout is also used by the ROM generator.
// The LDAC state is only part of the enum when MEMS_SPI_LDAC_EN is defined.
package mems_spi_pkg;

`ifdef MEMS_SPI_LDAC_EN
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_HOLD, ST_GAP, ST_LDAC} spi_state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_HOLD, ST_GAP} spi_state_t;
`endif

   localparam int DEF_WORD_BITS = 24;

   localparam int CMD_MSB  = 21;
   localparam int CMD_LSB  = 19;
   localparam int ADDR_MSB = 18;
   localparam int ADDR_LSB = 16;
   localparam int DATA_MSB = 15;
   localparam int DATA_LSB = 0;

   localparam logic [2:0] CMD_WRITE_UPDATE = 3'b011;
   localparam logic [2:0] CMD_RESET        = 3'b101;
   localparam logic [2:0] CMD_REF_SETUP    = 3'b111;

   function automatic logic [DEF_WORD_BITS-1:0] dac_word(input logic [2:0]  cmd,
                                                         input logic [2:0]  addr,
                                                         input logic [15:0] data);
      logic [DEF_WORD_BITS-1:0] w;
      w = '0;
      w[CMD_MSB:CMD_LSB]   = cmd;
      w[ADDR_MSB:ADDR_LSB] = addr;
      w[DATA_MSB:DATA_LSB] = data;
      return w;
   endfunction

endpackage

// File: rtl/mems_spi_clkgen.sv
// sclk phase divider: CLK_DIV cycles high then CLK_DIV cycles low while enabled.
// rise_tick/fall_tick flag the last cycle of a low/high phase, so the edge lands on the next clock.
module mems_spi_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          hi;

   // Disabled means parked at the start of a high phase, ready for the next frame.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= RELOAD;
         hi  <= 1'b1;
      end else if (cnt == '0) begin
         cnt <= RELOAD;
         hi  <= ~hi;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign fall_tick = en && hi && (cnt == '0);
   assign rise_tick = en && !hi && (cnt == '0);

endmodule

// File: rtl/mems_dac_spi.sv
// 3-wire SPI transmitter for the quad 16-bit MEMS mirror DAC: one ROM word per start pulse, MSB first.
// Define MEMS_SPI_LDAC_EN to add an ldac_n strobe after each frame for simultaneous channel update.
//  state | meaning
//  IDLE  | link idle, waiting for start
//  LOAD  | capture ROM word, arm bit counter
//  SHIFT | sync_n low, WORD_BITS sclk periods
//  HOLD  | sclk high after last bit, sync_n low
//  GAP   | sync_n high for GAP cycles
//  LDAC  | ldac_n low for CLK_DIV cycles
module mems_dac_spi
   import mems_spi_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int GAP       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WORD_BITS-1:0] data_in,
   output logic                 busy,
   output logic                 done,
   output logic                 sync_n,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 ldac_n
);

   localparam int BC_W = $clog2(WORD_BITS + 1);
   localparam int TW   = $clog2(((GAP > CLK_DIV) ? GAP : CLK_DIV) + 1);

   spi_state_t           state, state_nxt;
   logic [WORD_BITS-1:0] sreg, sreg_nxt;
   logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic [TW-1:0]        tmr, tmr_nxt;
   logic                 busy_nxt, done_nxt, sync_n_nxt, sclk_nxt, mosi_nxt;
   logic                 rise_tick, fall_tick;
   logic                 clk_en;

   assign clk_en = (state == ST_SHIFT) || (state == ST_HOLD);

   mems_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk       (clk),
      .rst       (rst),
      .en        (clk_en),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

`ifdef MEMS_SPI_LDAC_EN
   logic ldac_n_nxt;
`endif

   always_comb begin
      state_nxt   = state;
      sreg_nxt    = sreg;
      bit_cnt_nxt = bit_cnt;
      tmr_nxt     = tmr;
      sync_n_nxt  = sync_n;
      sclk_nxt    = sclk;
      mosi_nxt    = mosi;
`ifdef MEMS_SPI_LDAC_EN
      ldac_n_nxt  = 1'b1;
`endif
      case (state)
         ST_IDLE: begin
            sync_n_nxt = 1'b1;
            sclk_nxt   = 1'b1;
            mosi_nxt   = 1'b0;
            if (start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            sreg_nxt    = data_in;
            bit_cnt_nxt = BC_W'(WORD_BITS);
            sync_n_nxt  = 1'b0;
            sclk_nxt    = 1'b1;
            mosi_nxt    = data_in[WORD_BITS-1];
            state_nxt   = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (fall_tick) sclk_nxt = 1'b0;
            // New data goes out with the rising edge so it is stable around the next fall.
            if (rise_tick) begin
               sclk_nxt    = 1'b1;
               sreg_nxt    = sreg << 1;
               mosi_nxt    = sreg_nxt[WORD_BITS-1];
               bit_cnt_nxt = bit_cnt - BC_W'(1);
               if (bit_cnt == BC_W'(1)) state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (fall_tick) begin
               sync_n_nxt = 1'b1;
               mosi_nxt   = 1'b0;
               tmr_nxt    = TW'(GAP - 1);
               state_nxt  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr == '0) begin
`ifdef MEMS_SPI_LDAC_EN
               tmr_nxt    = TW'(CLK_DIV - 1);
               ldac_n_nxt = 1'b0;
               state_nxt  = ST_LDAC;
`else
               state_nxt  = ST_IDLE;
`endif
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
`ifdef MEMS_SPI_LDAC_EN
         ST_LDAC: begin
            if (tmr == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               ldac_n_nxt = 1'b0;
               tmr_nxt    = tmr - TW'(1);
            end
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_IDLE) && (state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         sreg    <= '0;
         bit_cnt <= '0;
         tmr     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sync_n  <= 1'b1;
         sclk    <= 1'b1;
         mosi    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sreg    <= sreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         tmr     <= tmr_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         sync_n  <= sync_n_nxt;
         sclk    <= sclk_nxt;
         mosi    <= mosi_nxt;
      end
   end

`ifdef MEMS_SPI_LDAC_EN
   always_ff @(posedge clk) begin
      if (rst) ldac_n <= 1'b1;
      else     ldac_n <= ldac_n_nxt;
   end
`else
   assign ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_mems_dac_spi.sv
// Self-checking bench for mems_dac_spi: per-cycle waveform model derived from the frame timing rules,
// falling-edge bit capture, directed vector table, random frames, back-to-back, mid-frame reset.
`timescale 1ns/1ps
module tb_mems_dac_spi;

`ifdef MEMS_SPI_LDAC_EN
   localparam int CD     = 3;
   localparam int LD     = 3;
   localparam int T_SPEC = 153;
`else
   localparam int CD     = 2;
   localparam int LD     = 0;
   localparam int T_SPEC = 101;
`endif
   localparam int W  = 24;
   localparam int G  = 2;
   localparam int SH = 2 * CD * W;
   localparam int T  = 1 + SH + CD + G + LD;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] data_in;
   logic         busy, done, sync_n, sclk, mosi, ldac_n;

   int checks = 0;
   int errors = 0;

   mems_dac_spi #(.CLK_DIV(CD), .WORD_BITS(W), .GAP(G)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .data_in (data_in),
      .busy    (busy),
      .done    (done),
      .sync_n  (sync_n),
      .sclk    (sclk),
      .mosi    (mosi),
      .ldac_n  (ldac_n)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs k cycles after the start cycle, from the frame timing rules.
   function automatic void model(input int k, input logic [W-1:0] word,
                                 output logic e_busy, output logic e_done, output logic e_sync_n,
                                 output logic e_sclk, output logic e_mosi, output logic e_ldac_n,
                                 output logic mosi_care);
      e_busy    = (k >= 1) && (k <= T);
      e_done    = (k == T + 1);
      e_sync_n  = !((k >= 2) && (k < 2 + SH + CD));
      e_sclk    = 1'b1;
      e_mosi    = 1'b0;
      mosi_care = 1'b1;
      if ((k >= 2) && (k < 2 + SH)) begin
         e_sclk = (((k - 2) % (2 * CD)) < CD);
         e_mosi = word[W - 1 - (k - 2) / (2 * CD)];
      end else if ((k >= 2 + SH) && (k < 2 + SH + CD)) begin
         mosi_care = 1'b0;
      end
      e_ldac_n = !((LD > 0) && (k > T - LD) && (k <= T));
   endfunction

   task automatic run_frame(input logic [W-1:0] word, input int extra_at, input logic [W-1:0] junk,
                            input logic [W-1:0] exp_rx, input int exp_done, input string tag);
      logic         eb, ed, es, ec, em, el, care;
      logic         prev_sclk;
      logic [W-1:0] rx;
      int           nfall, nbusy, ndone;
      rx = '0; nfall = 0; nbusy = 0; ndone = 0; prev_sclk = 1'b1;
      @(posedge clk); #1;
      start   = 1'b1;
      data_in = ~word;
      @(posedge clk); #1;
      start   = 1'b0;
      data_in = word;
      for (int k = 1; k <= T + 3; k++) begin
         if (k >= 2) begin
            start   = (k == extra_at);
            data_in = (k == extra_at || k == extra_at + 1) ? junk : W'($urandom);
         end
         @(negedge clk);
         model(k, word, eb, ed, es, ec, em, el, care);
         check({tag, "/busy"},   busy,   eb);
         check({tag, "/done"},   done,   ed);
         check({tag, "/sync_n"}, sync_n, es);
         check({tag, "/sclk"},   sclk,   ec);
         check({tag, "/ldac_n"}, ldac_n, el);
         if (care) check({tag, "/mosi"}, mosi, em);
         if (prev_sclk && !sclk && !sync_n) begin
            rx = {rx[W-2:0], mosi};
            nfall++;
         end
         prev_sclk = sclk;
         nbusy += int'(busy);
         ndone += int'(done);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, "/falls"},    nfall, W);
      check({tag, "/rx_word"},  rx,    exp_rx);
      check({tag, "/busy_len"}, nbusy, T_SPEC);
      check({tag, "/n_done"},   ndone, exp_done);
   endtask

   task automatic back_to_back();
      logic [W-1:0] words [3];
      logic [W-1:0] rx;
      logic         start_q, prev_sync, prev_sclk;
      int           idx, high_run, nframes, nbits, last_done;
      words[0] = 24'h280000;
      words[1] = 24'h380001;
      words[2] = 24'h1F8000;
      idx = 0; high_run = 0; nframes = 0; nbits = 0; last_done = -1; rx = '0;
      start_q = 1'b0; prev_sync = 1'b1; prev_sclk = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 3 * (T + 1) + 20; cyc++) begin
         data_in = start_q ? words[idx-1] : W'($urandom);
         if (!busy && !start_q && idx < 3) begin
            start = 1'b1;
            idx++;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (prev_sync && !sync_n) begin
            if (nframes > 0) check("b2b/sync_high_cycles", high_run, G + LD + 2);
            rx = '0;
            nbits = 0;
         end
         if (prev_sclk && !sclk && !sync_n) begin
            rx = {rx[W-2:0], mosi};
            nbits++;
         end
         if (!prev_sync && sync_n) begin
            if (nframes < 3) begin
               check("b2b/word", rx, words[nframes]);
               check("b2b/bits", nbits, W);
            end
            nframes++;
            high_run = 0;
         end
         if (sync_n) high_run++;
         if (done) begin
            if (last_done >= 0) check("b2b/done_spacing", cyc - last_done, T + 1);
            last_done = cyc;
         end
         prev_sync = sync_n;
         prev_sclk = sclk;
         start_q   = start;
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("b2b/frames", nframes, 3);
   endtask

   task automatic reset_mid();
      logic prev_sclk;
      int   nfall, ndone, nbusy;
      bit   fired;
      prev_sclk = 1'b1; nfall = 0; ndone = 0; nbusy = 0; fired = 1'b0;
      @(posedge clk); #1;
      start   = 1'b1;
      data_in = W'($urandom);
      @(posedge clk); #1;
      start   = 1'b0;
      data_in = 24'h5A5A5A;
      for (int k = 1; k <= T + 10 && !fired; k++) begin
         @(negedge clk);
         if (prev_sclk && !sclk && !sync_n) nfall++;
         prev_sclk = sclk;
         @(posedge clk); #1;
         if (nfall == 10) fired = 1'b1;
      end
      check("rstmid/falls_before_reset", nfall, 10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid/sync_n", sync_n, 1'b1);
      check("rstmid/busy",   busy,   1'b0);
      check("rstmid/done",   done,   1'b0);
      check("rstmid/sclk",   sclk,   1'b1);
      check("rstmid/mosi",   mosi,   1'b0);
      check("rstmid/ldac_n", ldac_n, 1'b1);
      for (int k = 0; k < T + 5; k++) begin
         @(negedge clk);
         ndone += int'(done);
         nbusy += int'(busy);
      end
      check("rstmid/no_done", ndone, 0);
      check("rstmid/stays_idle", nbusy, 0);
   endtask

   typedef struct {
      logic [W-1:0] word;
      int           extra_at;
      logic [W-1:0] junk;
      logic [W-1:0] exp_rx;
      int           exp_done;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{24'hA5F00F, 0,  24'h000000, 24'hA5F00F, 1};
      vecs[1] = '{24'hA5F00F, 20, 24'h123456, 24'hA5F00F, 1};
      vecs[2] = '{24'h000000, 0,  24'h000000, 24'h000000, 1};
      vecs[3] = '{24'hFFFFFF, 5,  24'h000000, 24'hFFFFFF, 1};
      vecs[4] = '{24'h800001, T,  24'h7FFFFE, 24'h800001, 1};
      vecs[5] = '{24'h555555, 2,  24'hAAAAAA, 24'h555555, 1};
      vecs[6] = '{24'h1F8000, T - 1, 24'hFFFFFF, 24'h1F8000, 1};

      rst     = 1'b1;
      start   = 1'b1;
      data_in = W'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset/sync_n", sync_n, 1'b1);
      check("reset/sclk",   sclk,   1'b1);
      check("reset/mosi",   mosi,   1'b0);
      check("reset/busy",   busy,   1'b0);
      check("reset/done",   done,   1'b0);
      check("reset/ldac_n", ldac_n, 1'b1);
      @(posedge clk); #1;
      rst   = 1'b0;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("idle/busy",   busy,   1'b0);
         check("idle/sync_n", sync_n, 1'b1);
      end

      for (int i = 0; i < 7; i++)
         run_frame(vecs[i].word, vecs[i].extra_at, vecs[i].junk, vecs[i].exp_rx, vecs[i].exp_done,
                   $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] w;
         int           ea;
         w  = W'($urandom);
         ea = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, T));
         run_frame(w, ea, W'($urandom), w, 1, $sformatf("rnd%0d", i));
      end

      back_to_back();
      reset_mid();
      run_frame(24'hC3A596, 0, 24'h000000, 24'hC3A596, 1, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
